// File: rtl/ifft_4_stream.sv
// Streaming 4-point radix-2 inverse FFT: loads X0..X3, runs two butterfly stages, streams x0..x3.
// Build option: define IFFT_ROUND_EN for round-half-up scaling (default build truncates).
module ifft_4_stream #(
   parameter int IN_W  = 18,
   parameter int OUT_W = 16
) (
   input  logic                    clk,
   input  logic                    reset_,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic signed [IN_W-1:0]  in_r,
   input  logic signed [IN_W-1:0]  in_i,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic signed [OUT_W-1:0] out_r,
   output logic signed [OUT_W-1:0] out_i,
   output logic                    out_last,
   output logic                    busy
);

   localparam int AW = IN_W + 1;
   localparam int SW = IN_W + 2;

   typedef enum logic [1:0] {LOAD, S1, S2, OUT} state_t;

   state_t state, state_nxt;
   logic [1:0] cnt, ocnt;

   logic signed [IN_W-1:0]  xr [4];
   logic signed [IN_W-1:0]  xi [4];
   logic signed [AW-1:0]    ar, ai, br, bi, cr, ci, dr, di;
   logic signed [SW-1:0]    sr [4];
   logic signed [SW-1:0]    si [4];
   logic signed [OUT_W-1:0] yr [4];
   logic signed [OUT_W-1:0] yi [4];

   // Divide by 4 (optionally rounding), then clamp to the OUT_W signed range.
   function automatic logic signed [OUT_W-1:0] scale(input logic signed [SW-1:0] s);
      logic signed [SW:0] t;
      logic [SW-2:0]      q;
`ifdef IFFT_ROUND_EN
      t = {s[SW-1], s} + (SW+1)'(2);
`else
      t = {s[SW-1], s};
`endif
      q = t[SW:2];
      if (q[SW-2:OUT_W-1] == {(SW-OUT_W){q[SW-2]}})
         scale = q[OUT_W-1:0];
      else if (q[SW-2])
         scale = {1'b1, {(OUT_W-1){1'b0}}};
      else
         scale = {1'b0, {(OUT_W-1){1'b1}}};
   endfunction

   always_ff @(posedge clk) begin
      if (!reset_) state <= LOAD;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         LOAD:    if (in_valid && cnt == 2'd3) state_nxt = S1;
         S1:      state_nxt = S2;
         S2:      state_nxt = OUT;
         OUT:     if (out_ready && ocnt == 2'd3) state_nxt = LOAD;
         default: state_nxt = LOAD;
      endcase
   end

   // Second butterfly stage: W^(-1) = +j, so the odd outputs rotate d by +/-j.
   always_comb begin
      sr[0] = SW'(ar) + SW'(cr);
      si[0] = SW'(ai) + SW'(ci);
      sr[1] = SW'(br) - SW'(di);
      si[1] = SW'(bi) + SW'(dr);
      sr[2] = SW'(ar) - SW'(cr);
      si[2] = SW'(ai) - SW'(ci);
      sr[3] = SW'(br) + SW'(di);
      si[3] = SW'(bi) - SW'(dr);
   end

   always_ff @(posedge clk) begin
      if (!reset_) begin
         cnt  <= '0;
         ocnt <= '0;
         ar <= '0; ai <= '0; br <= '0; bi <= '0;
         cr <= '0; ci <= '0; dr <= '0; di <= '0;
         for (int k = 0; k < 4; k++) begin
            xr[k] <= '0;
            xi[k] <= '0;
            yr[k] <= '0;
            yi[k] <= '0;
         end
      end else begin
         if (state == LOAD && in_valid) begin
            xr[cnt] <= in_r;
            xi[cnt] <= in_i;
            cnt     <= cnt + 2'd1;
         end
         if (state == S1) begin
            ar <= AW'(xr[0]) + AW'(xr[2]);
            ai <= AW'(xi[0]) + AW'(xi[2]);
            br <= AW'(xr[0]) - AW'(xr[2]);
            bi <= AW'(xi[0]) - AW'(xi[2]);
            cr <= AW'(xr[1]) + AW'(xr[3]);
            ci <= AW'(xi[1]) + AW'(xi[3]);
            dr <= AW'(xr[1]) - AW'(xr[3]);
            di <= AW'(xi[1]) - AW'(xi[3]);
         end
         if (state == S2) begin
            for (int k = 0; k < 4; k++) begin
               yr[k] <= scale(sr[k]);
               yi[k] <= scale(si[k]);
            end
         end
         if (state == OUT && out_ready) ocnt <= ocnt + 2'd1;
      end
   end

   assign in_ready  = (state == LOAD);
   assign out_valid = (state == OUT);
   assign out_last  = (state == OUT) && (ocnt == 2'd3);
   assign out_r     = yr[ocnt];
   assign out_i     = yi[ocnt];
   assign busy      = !((state == LOAD) && (cnt == 2'd0));

endmodule

// File: tb/tb_ifft_4_stream.sv
// Bench for ifft_4_stream: DFT-formula model feeds an expected queue, a forked monitor pops on output handshakes.
module tb_ifft_4_stream;

   logic        clk = 1'b0;
   logic        reset_;
   logic        in_valid;
   logic        in_ready;
   logic [17:0] in_r, in_i;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_r, out_i;
   logic        out_last;
   logic        busy;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int hs_cyc = 0;
   int out_count = 0;

   logic [32:0] exp_q[$];

   ifft_4_stream #(.IN_W(18), .OUT_W(16)) dut (
      .clk(clk), .reset_(reset_),
      .in_valid(in_valid), .in_ready(in_ready), .in_r(in_r), .in_i(in_i),
      .out_valid(out_valid), .out_ready(out_ready), .out_r(out_r), .out_i(out_i),
      .out_last(out_last), .busy(busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #2000000;
      $display("FAIL global_timeout");
      $fatal(1, "bench timeout");
   end

   function automatic int scale_m(input int s);
      int q;
`ifdef IFFT_ROUND_EN
      q = (s + 2) >>> 2;
`else
      q = s >>> 2;
`endif
      if (q > 32767) q = 32767;
      if (q < -32768) q = -32768;
      return q;
   endfunction

   // x[n] = 1/4 * sum_k X[k] * j^(n*k)
   function automatic void model(input int br[4], input int bi[4]);
      int sr, si;
      for (int n = 0; n < 4; n++) begin
         sr = 0; si = 0;
         for (int k = 0; k < 4; k++) begin
            case ((n * k) % 4)
               0: begin sr += br[k]; si += bi[k]; end
               1: begin sr -= bi[k]; si += br[k]; end
               2: begin sr -= br[k]; si -= bi[k]; end
               default: begin sr += bi[k]; si -= br[k]; end
            endcase
         end
         exp_q.push_back({1'(n == 3), 16'(scale_m(sr)), 16'(scale_m(si))});
      end
   endfunction

   task automatic monitor();
      logic        held_v = 1'b0;
      logic [32:0] held = '0;
      logic [32:0] got, want;
      forever begin
         @(negedge clk);
         if (reset_ && out_valid) begin
            got = {out_last, out_r, out_i};
            checks++;
            if (in_ready !== 1'b0) begin
               errors++;
               $display("FAIL in_ready_in_out: got %b want 0", in_ready);
            end
            if (held_v) begin
               checks++;
               if (got !== held) begin
                  errors++;
                  $display("FAIL stall_hold: got %h want %h", got, held);
               end
            end
            if (out_ready) begin
               held_v = 1'b0;
               out_count++;
               checks++;
               if (exp_q.size() == 0) begin
                  errors++;
                  $display("FAIL out_unexpected: got %h with empty queue", got);
               end else begin
                  want = exp_q.pop_front();
                  if (got !== want) begin
                     errors++;
                     $display("FAIL out_sample: got last=%b r=%h i=%h want last=%b r=%h i=%h",
                              got[32], got[31:16], got[15:0], want[32], want[31:16], want[15:0]);
                  end
               end
            end else begin
               held_v = 1'b1;
               held   = got;
            end
         end else begin
            held_v = 1'b0;
         end
      end
   endtask

   task automatic drive_bin(input int r, input int i, input bit gaps);
      bit ok = 0;
      if (gaps) begin
         repeat ($urandom_range(0, 3)) begin
            in_valid = 1'b0;
            in_r = 18'($urandom);
            in_i = 18'($urandom);
            @(posedge clk); #1;
         end
      end
      in_valid = 1'b1;
      in_r = 18'(r);
      in_i = 18'(i);
      for (int n = 0; n < 50 && !ok; n++) begin
         @(negedge clk);
         if (in_ready) ok = 1;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      hs_cyc = cyc;
      checks++;
      if (ok !== 1'b1) begin
         errors++;
         $display("FAIL in_handshake_timeout: got no in_ready within 50 cycles want handshake");
      end
   endtask

   task automatic send_block(input int br[4], input int bi[4], input bit gaps, output int first_hs);
      model(br, bi);
      first_hs = 0;
      for (int k = 0; k < 4; k++) begin
         drive_bin(br[k], bi[k], gaps);
         if (k == 0) first_hs = hs_cyc;
      end
   endtask

   task automatic wait_drain(input string name);
      for (int n = 0; n < 200 && exp_q.size() != 0; n++) begin
         @(posedge clk); #1;
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain_%s: got %0d samples pending want 0", name, exp_q.size());
      end
   endtask

   task automatic test_reset();
      reset_ = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      checks++;
      if ({in_ready, out_valid, out_last, busy, out_r, out_i} !== {1'b1, 1'b0, 1'b0, 1'b0, 32'h0}) begin
         errors++;
         $display("FAIL reset_outputs: got rdy=%b vld=%b last=%b busy=%b r=%h i=%h want 1 0 0 0 0000 0000",
                  in_ready, out_valid, out_last, busy, out_r, out_i);
      end
      reset_ = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_round_trip();
      int br[4] = '{1536, -1024, -512, 0};
      int bi[4] = '{1536, 0, -512, -1024};
      int t;
      send_block(br, bi, 1'b0, t);
      checks++;
      if ({in_ready, out_valid, busy} !== 3'b001) begin
         errors++;
         $display("FAIL rt_s1_state: got rdy=%b vld=%b busy=%b want 0 0 1", in_ready, out_valid, busy);
      end
      @(posedge clk); #1;
      checks++;
      if ({in_ready, out_valid} !== 2'b00) begin
         errors++;
         $display("FAIL rt_s2_state: got rdy=%b vld=%b want 0 0", in_ready, out_valid);
      end
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1) begin
         errors++;
         $display("FAIL rt_latency: got out_valid=%b in 3rd cycle want 1", out_valid);
      end
      wait_drain("round_trip");
   endtask

   task automatic test_impulse();
      int br[4] = '{0, 1024, 0, 0};
      int bi[4] = '{0, 0, 0, 0};
      int t;
      send_block(br, bi, 1'b0, t);
      wait_drain("impulse");
   endtask

   task automatic test_saturation();
      int br[4] = '{131071, 131071, 131071, 131071};
      int bi[4] = '{0, 0, 0, 0};
      int t;
      send_block(br, bi, 1'b0, t);
      wait_drain("saturation");
   endtask

   task automatic test_scaling();
      int bp[4] = '{2, 0, 0, 0};
      int bn[4] = '{-2, 0, 0, 0};
      int bz[4] = '{0, 0, 0, 0};
      int t;
      send_block(bp, bz, 1'b0, t);
      send_block(bn, bz, 1'b0, t);
      wait_drain("scaling");
   endtask

   task automatic test_random();
      int br[4], bi[4];
      logic [17:0] v;
      int t;
      for (int b = 0; b < 4; b++) begin
         for (int k = 0; k < 4; k++) begin
            v = 18'($urandom); br[k] = int'($signed(v));
            v = 18'($urandom); bi[k] = int'($signed(v));
         end
         send_block(br, bi, 1'b1, t);
      end
      wait_drain("random");
   endtask

   task automatic test_handshake();
      int br[4] = '{1000, -300, 77, 4096};
      int bi[4] = '{-5, 250, -800, 12};
      int t;
      bit seen = 0;
      send_block(br, bi, 1'b1, t);
      for (int n = 0; n < 20 && !seen; n++) begin
         @(posedge clk); #1;
         if (out_valid) seen = 1;
      end
      checks++;
      if (seen !== 1'b1) begin
         errors++;
         $display("FAIL hs_out_valid_timeout: got no out_valid want out_valid");
      end
      @(posedge clk); #1;
      out_ready = 1'b0;
      repeat (5) begin
         in_valid = 1'b1;
         in_r = 18'($urandom);
         in_i = 18'($urandom);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      wait_drain("handshake");
   endtask

   task automatic test_back_to_back();
      int ba[4] = '{256, 512, -256, 100};
      int bb[4] = '{-1024, 64, 32, -16};
      int ta, tb;
      send_block(ba, bb, 1'b0, ta);
      send_block(bb, ba, 1'b0, tb);
      checks++;
      if (tb - ta !== 10) begin
         errors++;
         $display("FAIL block_period: got %0d cycles want 10", tb - ta);
      end
      wait_drain("back_to_back");
   endtask

   task automatic test_reset_mid();
      int base;
      int t;
      int ra[4] = '{1536, -1024, -512, 0};
      int ri[4] = '{1536, 0, -512, -1024};
      drive_bin(700, 700, 1'b0);
      drive_bin(-700, 300, 1'b0);
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL busy_loading: got %b want 1", busy);
      end
      reset_ = 1'b0;
      @(posedge clk); #1;
      reset_ = 1'b1;
      checks++;
      if ({in_ready, out_valid, busy} !== 3'b100) begin
         errors++;
         $display("FAIL reset_mid_load: got rdy=%b vld=%b busy=%b want 1 0 0", in_ready, out_valid, busy);
      end
      send_block(ra, ri, 1'b0, t);
      wait_drain("after_load_reset");

      base = out_count;
      send_block(ri, ra, 1'b0, t);
      for (int n = 0; n < 30 && out_count != base + 2; n++) begin
         @(posedge clk); #1;
      end
      out_ready = 1'b0;
      checks++;
      if (out_count !== base + 2) begin
         errors++;
         $display("FAIL reach_ocnt2: got %0d outputs want %0d", out_count - base, 2);
      end
      reset_ = 1'b0;
      @(posedge clk); #1;
      reset_ = 1'b1;
      exp_q.delete();
      checks++;
      if ({in_ready, out_valid, out_last} !== 3'b100) begin
         errors++;
         $display("FAIL reset_mid_out: got rdy=%b vld=%b last=%b want 1 0 0", in_ready, out_valid, out_last);
      end
      out_ready = 1'b1;
      send_block(ra, ri, 1'b0, t);
      wait_drain("after_out_reset");
   endtask

   initial begin
      reset_ = 1'b0;
      in_valid = 1'b0;
      in_r = '0;
      in_i = '0;
      out_ready = 1'b1;
      fork
         monitor();
      join_none
      test_reset();
      test_round_trip();
      test_impulse();
      test_saturation();
      test_scaling();
      test_random();
      test_handshake();
      test_back_to_back();
      test_reset_mid();
      repeat (3) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
